// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    REQ_LD = 2'd0,
    REQ_D  = 2'd1,
    REQ_I  = 2'd2
  } req_id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int unsigned MEM_LAT_MAX = 15;
  localparam int unsigned CNT_W       = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of mem_port_arbiter.
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32
);
  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_done;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_done;

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_done;

  logic [31:0]   rdata;
  logic          busy;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;

  modport slave (
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  i_req, i_addr,
    input  m_rdata,
    output ld_done, d_done, i_done, rdata, busy,
    output m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output ld_req, ld_we, ld_addr, ld_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output i_req, i_addr,
    output m_rdata,
    input  ld_done, d_done, i_done, rdata, busy,
    input  m_en, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner selector: LD always wins; D vs I is fixed D-first,
// or round-robin on the last-grant pointer when ARB_RR_EN is defined.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic    ld_req,
  input  logic    d_req,
  input  logic    i_req,
`ifdef ARB_RR_EN
  input  logic    last_d,
`endif
  output req_id_t winner,
  output logic    valid
);

  always_comb begin
    winner = REQ_LD;
    valid  = ld_req | d_req | i_req;
    if (ld_req) begin
      winner = REQ_LD;
`ifdef ARB_RR_EN
    end else if (d_req && i_req) begin
      // Whoever was not granted last gets this slot.
      winner = last_d ? REQ_I : REQ_D;
`endif
    end else if (d_req) begin
      winner = REQ_D;
    end else if (i_req) begin
      winner = REQ_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter in front of a fixed-latency single-port memory.
// Define ARB_RR_EN for round-robin between the data and fetch ports.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  req_id_t           win_q, win_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;

  req_id_t           pick_win;
  logic              pick_valid;

`ifdef ARB_RR_EN
  logic              last_d_q, last_d_d;
`endif

  arb_pick u_pick (
    .ld_req (bus.ld_req),
    .d_req  (bus.d_req),
    .i_req  (bus.i_req),
`ifdef ARB_RR_EN
    .last_d (last_d_q),
`endif
    .winner (pick_win),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          win_d   = pick_win;
          state_d = ISSUE;
          case (pick_win)
            REQ_LD: begin
              we_d    = bus.ld_we;
              addr_d  = bus.ld_addr;
              wdata_d = bus.ld_wdata;
            end
            REQ_D: begin
              we_d    = bus.d_we;
              addr_d  = bus.d_addr;
              wdata_d = bus.d_wdata;
            end
            default: begin
              we_d    = 1'b0;
              addr_d  = bus.i_addr;
              wdata_d = '0;
            end
          endcase
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = bus.m_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef ARB_RR_EN
  always_comb begin
    last_d_d = last_d_q;
    // Only D/I grants move the pointer; an LD grant leaves it alone.
    if (state_q == IDLE && pick_valid && pick_win != REQ_LD) begin
      last_d_d = (pick_win == REQ_D);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      win_q   <= REQ_LD;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    bus.busy    = (state_q != IDLE);
    bus.m_en    = (state_q == ISSUE);
    bus.m_we    = (state_q == ISSUE) && we_q;
    bus.m_addr  = addr_q;
    bus.m_wdata = wdata_q;
    bus.rdata   = rdata_q;
    bus.ld_done = (state_q == RESP) && (win_q == REQ_LD);
    bus.d_done  = (state_q == RESP) && (win_q == REQ_D);
    bus.i_done  = (state_q == RESP) && (win_q == REQ_I);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner
// sequences, and random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW      = 32;
  localparam int unsigned MEM_LAT = 2;
  localparam int          NRAND   = 800;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW)) bus ();

  mem_port_arbiter #(.AW(AW), .MEM_LAT(MEM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: one word per address, read data MEM_LAT cycles after m_en.
  logic [31:0] mem  [64];
  logic [31:0] pipe [MEM_LAT];
  logic        pl_we = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_we) mem[pl_idx] <= pl_data;
    else if (bus.m_en && bus.m_we) mem[bus.m_addr[7:2]] <= bus.m_wdata;
    pipe[0] <= bus.m_en ? mem[bus.m_addr[7:2]] : 32'hBAD0_0000;
    for (int k = 1; k < MEM_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.m_rdata = pipe[MEM_LAT-1];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          who;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [6];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] dones();
    return {bus.i_done, bus.d_done, bus.ld_done};
  endfunction

  task automatic drive(input int who, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd);
    case (who)
      0: begin
        bus.ld_req = req; bus.ld_we = we; bus.ld_addr = addr; bus.ld_wdata = wd;
      end
      1: begin
        bus.d_req = req; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
      end
      default: begin
        bus.i_req = req; bus.i_addr = addr;
      end
    endcase
  endtask

  task automatic idle_all();
    for (int r = 0; r < 3; r++) drive(r, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    repeat (cycles) tick();
    rst = 1'b1;
  endtask

  // Called in the IDLE cycle T in which the request is sampled; returns in T+3+MEM_LAT.
  task automatic expect_access(input string tag, input int who, input logic we,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic chk_rd, input logic [31:0] exp_rd);
    tick();
    chk({tag, " issue"}, {bus.busy, bus.m_en, bus.m_we, bus.m_addr, bus.m_wdata},
        {1'b1, 1'b1, we, addr, wd});
    for (int c = 0; c < MEM_LAT; c++) begin
      tick();
      chk({tag, " wait"}, {bus.busy, bus.m_en, dones()}, {1'b1, 1'b0, 3'b000});
    end
    tick();
    chk({tag, " done"}, {bus.busy, bus.m_en, dones()}, {1'b1, 1'b0, 3'b001 << who});
    if (chk_rd) chk({tag, " rdata"}, bus.rdata, exp_rd);
    drive(who, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk({tag, " idle"}, {bus.busy, bus.m_en, dones()}, 5'b0);
  endtask

  int          q_fair [$];
  int          exp_f  [4];
  logic [31:0] ref_mem [64];

  initial begin
    idle_all();
    vt[0] = '{2, 1'b0, 32'h04, 32'h0,        1'b1, 32'h2001000A};
    vt[1] = '{0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
    vt[2] = '{1, 1'b0, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF};
    vt[3] = '{1, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'h0};
    vt[4] = '{2, 1'b0, 32'h20, 32'h0,        1'b1, 32'h12345678};
    vt[5] = '{0, 1'b0, 32'h04, 32'h0,        1'b1, 32'h2001000A};

    // Reset with every requester asserting: nothing may move.
    pl_we = 1'b1; pl_idx = 6'd1; pl_data = 32'h2001000A;
    drive(0, 1'b1, 1'b1, 32'h30, 32'hA5A5A5A5);
    drive(1, 1'b1, 1'b0, 32'h34, 32'h0);
    drive(2, 1'b1, 1'b0, 32'h38, 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      pl_we = 1'b0;
      chk("reset ctl", {bus.m_en, bus.m_we, bus.busy, dones(), bus.rdata}, 38'h0);
      chk("reset dp", {bus.m_addr, bus.m_wdata}, 64'h0);
    end
    rst = 1'b1;
    tick();
    chk("reset first grant", {bus.m_en, bus.m_we, bus.m_addr, bus.m_wdata},
        {1'b1, 1'b1, 32'h30, 32'hA5A5A5A5});
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (MEM_LAT + 1) tick();
    chk("reset ld done", dones(), 3'b001);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("reset idle", bus.busy, 1'b0);

    // Isolated accesses from the vector table.
    for (int v = 0; v < 6; v++) begin
      drive(vt[v].who, 1'b1, vt[v].we, vt[v].addr, vt[v].wdata);
      expect_access($sformatf("vec%0d", v), vt[v].who, vt[v].we, vt[v].addr,
                    vt[v].wdata, vt[v].chk_rd, vt[v].exp_rd);
    end

    // D and I together after reset: D first, I in the very next slot.
    do_reset(2);
    tick();
    drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(2, 1'b1, 1'b0, 32'h04, 32'h0);
    expect_access("contend d", 1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
    expect_access("contend i", 2, 1'b0, 32'h04, 32'h0, 1'b1, 32'h2001000A);

    // LD preempts a simultaneous D read of the word it writes.
    drive(0, 1'b1, 1'b1, 32'h18, 32'h0BADF00D);
    drive(1, 1'b1, 1'b0, 32'h18, 32'h0);
    expect_access("preempt ld", 0, 1'b1, 32'h18, 32'h0BADF00D, 1'b0, 32'h0);
    expect_access("preempt d", 1, 1'b0, 32'h18, 32'h0, 1'b1, 32'h0BADF00D);

    // Reset pulse during WAIT abandons the fetch; held i_req restarts it.
    drive(2, 1'b1, 1'b0, 32'h04, 32'h0);
    tick();
    chk("abort issue", {bus.m_en, bus.m_addr}, {1'b1, 32'h04});
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort quiet", {bus.busy, bus.m_en, dones()}, 5'b0);
    expect_access("abort retry", 2, 1'b0, 32'h04, 32'h0, 1'b1, 32'h2001000A);

    // Fairness with D and I held for four slots.
`ifdef ARB_RR_EN
    exp_f = '{1, 2, 1, 2};
`else
    exp_f = '{1, 1, 1, 1};
`endif
    do_reset(2);
    tick();
    drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(2, 1'b1, 1'b0, 32'h04, 32'h0);
    for (int c = 0; c < 4 * (MEM_LAT + 3); c++) begin
      tick();
      if (bus.d_done) q_fair.push_back(1);
      if (bus.i_done) q_fair.push_back(2);
    end
    idle_all();
    chk("fair count", q_fair.size(), 4);
    for (int k = 0; k < 4 && k < q_fair.size(); k++) begin
      chk($sformatf("fair grant%0d", k), q_fair[k], exp_f[k]);
    end
    tick();
    chk("fair idle", bus.busy, 1'b0);

    // Random traffic against a transaction-level model.
    do_reset(2);
    for (int k = 0; k < 64; k++) ref_mem[k] = mem[k];
    begin
      bit          pend = 0, last_d = 0;
      int          g_cyc = 0, g_who = 0, idle_from = 0;
      logic        g_we = 0;
      logic [31:0] g_addr = 0, g_wd = 0, g_rd = 0;
      bit          act [3];
      logic        a_we [3];
      logic [31:0] a_addr [3];
      logic [31:0] a_wd [3];
      logic        exp_en, exp_busy;
      logic [2:0]  exp_done;
      for (int r = 0; r < 3; r++) begin
        act[r] = 0; a_we[r] = 0; a_addr[r] = 0; a_wd[r] = 0;
      end
      for (int n = 0; n < NRAND; n++) begin
        tick();
        exp_en = 0; exp_busy = 0; exp_done = 3'b000;
        if (pend) begin
          exp_en   = (n == g_cyc + 1);
          exp_busy = (n > g_cyc);
          if (n == g_cyc + 2 + MEM_LAT) exp_done = 3'b001 << g_who;
        end
        chk("rand ctl", {bus.busy, bus.m_en, dones()}, {exp_busy, exp_en, exp_done});
        if (exp_en) chk("rand issue", {bus.m_we, bus.m_addr, bus.m_wdata}, {g_we, g_addr, g_wd});
        if (exp_done != 0 && !g_we) chk("rand rdata", bus.rdata, g_rd);
        if (exp_done != 0) begin
          pend = 0; act[g_who] = 0; idle_from = n + 1;
        end
        for (int r = 0; r < 3; r++) begin
          if (!act[r] && $urandom_range(0, 99) < 35) begin
            act[r]    = 1;
            a_we[r]   = (r == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            a_addr[r] = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            a_wd[r]   = (r == 2) ? 32'h0 : $urandom;
          end
          drive(r, act[r], a_we[r], a_addr[r], a_wd[r]);
        end
        if (!pend && n >= idle_from && (act[0] || act[1] || act[2])) begin
          if (act[0]) g_who = 0;
`ifdef ARB_RR_EN
          else if (act[1] && act[2]) g_who = last_d ? 2 : 1;
`endif
          else if (act[1]) g_who = 1;
          else g_who = 2;
          if (g_who == 1) last_d = 1;
          else if (g_who == 2) last_d = 0;
          pend   = 1;
          g_cyc  = n;
          g_we   = a_we[g_who];
          g_addr = a_addr[g_who];
          g_wd   = a_wd[g_who];
          g_rd   = ref_mem[g_addr[7:2]];
          if (g_we) ref_mem[g_addr[7:2]] = g_wd;
        end
      end
    end
    idle_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between three requesters: external program loader (LD), CPU data port (lw/sw, D), and CPU instruction fetch (I).
- Sequences each access through a fixed-latency memory and returns a one-cycle done pulse with read data.
- Sits between mips_cpu's fetch/data ports and the memory model, so the CPU can run from one memory and stall on contention.

Parameters:
- AW, 32, address width; byte addresses passed through unmodified.
- MEM_LAT, 2, memory read latency in cycles, legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- ld_req  in  1  loader access request (level).
- ld_we  in  1  loader write enable.
- ld_addr  in  AW  loader address.
- ld_wdata  in  32  loader write data.
- ld_done  out  1  loader access complete (1-cycle pulse).
- d_req  in  1  data access request.
- d_we  in  1  data write enable (sw).
- d_addr  in  AW  data address.
- d_wdata  in  32  data write data.
- d_done  out  1  data access complete.
- i_req  in  1  fetch request (read only).
- i_addr  in  AW  fetch address.
- i_done  out  1  fetch complete.
- rdata  out  32  read data; valid in the cycle any *_done is high.
- busy  out  1  high in every state except IDLE.
- m_en  out  1  memory access strobe.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data, valid MEM_LAT cycles after the m_en cycle.

Behaviour:
- Reset (rst=0 at a clk edge) is valid in any state.
  - State goes to IDLE; all outputs are 0, including rdata, m_addr and m_wdata.
  - The round-robin pointer is cleared.
  - Any in-flight access is abandoned: no done pulse, and its late m_rdata is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any req is high, select a winner, latch its we/addr/wdata into m_* registers, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle): m_en=1, m_we as latched. Load the counter with MEM_LAT-1, then go to WAIT.
  - WAIT (MEM_LAT cycles): m_en=0. Decrement the counter. When the counter is 0, capture m_rdata into rdata and go to RESP.
  - RESP (1 cycle): the winner's done=1 and rdata is held. Next state is IDLE.
- Timing, with req sampled in IDLE cycle T:
  - m_en is high in T+1.
  - done is high in T+2+MEM_LAT.
  - The next arbitration happens in T+3+MEM_LAT.
  - Throughput is one access per MEM_LAT+3 cycles.
- Writes follow the same sequence. rdata after a write equals whatever m_rdata returned; it is don't-care to requesters.
- Handshake:
  - req is a level signal. A requester holds req, we, addr and wdata stable until its done.
  - If req drops mid-access, the access still completes and done still pulses. Aborts are not supported.
  - req still high in the IDLE cycle after done starts a new access. This is intended for back-to-back fetch.
  - Requesters derive CPU stall as req & ~done.
- Priority: LD always wins. Between D and I, see the Optional Feature.
- Non-winners see no response and simply keep waiting. Requests are never dropped.
- Only one done is high per cycle, and only in RESP.
- rdata, m_addr and m_wdata hold their values in IDLE; they are not cleared.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined:
  - D/I arbitration is round-robin using a 1-bit last-grant pointer, updated on each D or I grant.
  - With both D and I requesting, the one not last granted wins.
  - An LD grant leaves the pointer unchanged.
- Undefined: fixed priority LD > D > I, and the pointer logic is absent.

Decomposition:
- Package mem_arb_pkg holds:
  - requester IDs REQ_LD=2'd0, REQ_D=2'd1, REQ_I=2'd2;
  - state encoding IDLE/ISSUE/WAIT/RESP (2-bit);
  - MEM_LAT_MAX=15 and counter width 4.
- Sub-module arb_pick: a combinational winner selector taking the three reqs and the pointer, returning a winner ID plus a valid flag. Its RR logic sits under ARB_RR_EN.
- The FSM, counter and datapath registers stay in mem_port_arbiter.

Test Plan (MEM_LAT=2; memory model is a 1-word-per-address array):
- Reset: hold rst=0 for 3 cycles with all reqs=1 -> m_en, busy, all done and rdata stay 0. After release, the first m_en is for LD.
- Fetch only: i_req=1, i_addr=0x00000004, mem[0x04]=0x2001000A, sampled at T -> m_en=1 at T+1; i_done=1 with rdata=0x2001000A at T+4; busy=0 at T+5.
- Contention, macro undefined: d_req and i_req both rise at T -> d_done at T+4; i granted at T+5; i_done at T+9.
- Loader write then data read:
  - ld_we=1, ld_addr=0x10, ld_wdata=0xDEADBEEF -> m_we=1, m_addr=0x10, m_wdata=0xDEADBEEF, then ld_done.
  - Then d_req read of 0x10 -> d_done with rdata=0xDEADBEEF.
  - LD preempts a simultaneous D request.
- Reset mid-operation: rst=0 for 1 cycle during WAIT -> no done pulse. Next cycle is IDLE; a held i_req restarts and completes 5 cycles later.
- Fairness: D and I held continuously for 4 accesses -> with ARB_RR_EN, grants go D, I, D, I; without it, grants go D, D, D, D and i_done never fires.
